// File: rtl/fifo_sb_pkg.sv
// Shared types and constants for the FIFO scoreboard slice.
package fifo_sb_pkg;

  typedef enum logic {
    SB_RUN  = 1'b0,
    SB_HALT = 1'b1
  } sb_state_e;

  localparam int ERR_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_sb_model.sv
// Reference FIFO model: storage, wrapping pointers and an entry count.
// Callers decide legality; push/pop here are already qualified.
module fifo_sb_model
  import fifo_sb_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] rd_data
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Storage is not reset; it is only read once count says it holds data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_scoreboard.sv
// Passive checker for a FIFO: tracks a model of its contents, flags
// overflow/underflow/data mismatch and optionally halts on the first error.
module fifo_scoreboard
  import fifo_sb_pkg::*;
#(
  parameter  int DATA_W      = 4,
  parameter  int DEPTH       = 4,
  parameter  int READ_LAT    = 0,
  parameter  int STOP_ON_ERR = 0,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 vld_in,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 vld_out,
  input  logic [DATA_W-1:0]    data_out,
  input  logic                 clr_err,
  output logic [CW-1:0]        occupancy,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_mismatch,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [DATA_W-1:0]    err_exp,
  output logic [DATA_W-1:0]    err_act,
  output logic                 halted
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  sb_state_e         state;
  logic              run;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] rd_data;
  logic              empty, full;
  logic              push, pop, flush;
  logic              ovf, udf, mis, new_err;
  logic [DATA_W-1:0] exp_now;
  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;

  assign run   = (state == SB_RUN);
  assign empty = (count == '0);
  assign full  = (count == FULL);

  // Simultaneous read/write is always legal: full frees a slot, empty falls through.
  assign push  = run && vld_in  && (!full  || vld_out);
  assign pop   = run && vld_out && (!empty || vld_in);
  assign flush = !run && clr_err;

  assign ovf   = run && vld_in  && !vld_out && full;
  assign udf   = run && vld_out && !vld_in  && empty;

  // On an empty model the word being written is the one being read.
  assign exp_now = empty ? data_in : rd_data;

  fifo_sb_model #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CW     (CW)
  ) u_model (
    .clk     (clk),
    .rst_b   (rst_b),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (data_in),
    .count   (count),
    .rd_data (rd_data)
  );

  generate
    if (READ_LAT == 0) begin : g_lat0
      assign cmp_vld = pop;
      assign cmp_exp = exp_now;
    end else begin : g_lat1
      logic              p_vld;
      logic [DATA_W-1:0] p_exp;
      // Hold the expected word one cycle; pop is low in HALT so this drains.
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          p_vld <= 1'b0;
          p_exp <= '0;
        end else begin
          p_vld <= pop;
          p_exp <= exp_now;
        end
      end
      assign cmp_vld = run && p_vld;
      assign cmp_exp = p_exp;
    end
  endgenerate

  assign mis     = cmp_vld && (cmp_exp != data_out);
  assign new_err = ovf || udf || mis;

  // FSM plus sticky flags, capture registers and saturating error counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= SB_RUN;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_mismatch  <= 1'b0;
      err_cnt       <= '0;
      err_exp       <= '0;
      err_act       <= '0;
    end else if (!run) begin
      if (clr_err) begin
        state         <= SB_RUN;
        err_overflow  <= 1'b0;
        err_underflow <= 1'b0;
        err_mismatch  <= 1'b0;
        err_cnt       <= '0;
        err_exp       <= '0;
        err_act       <= '0;
      end
    end else begin
      if (clr_err) begin
        // A fresh error in the clearing cycle survives the clear.
        err_overflow  <= ovf;
        err_underflow <= udf;
        err_mismatch  <= mis;
        err_cnt       <= {{(ERR_CNT_W-1){1'b0}}, new_err};
        err_exp       <= mis ? cmp_exp  : '0;
        err_act       <= mis ? data_out : '0;
      end else begin
        err_overflow  <= err_overflow  | ovf;
        err_underflow <= err_underflow | udf;
        err_mismatch  <= err_mismatch  | mis;
        if (new_err) err_cnt <= sat_inc(err_cnt);
        if (mis && !err_mismatch) begin
          err_exp <= cmp_exp;
          err_act <= data_out;
        end
      end
      if ((STOP_ON_ERR != 0) && new_err) state <= SB_HALT;
    end
  end

  assign occupancy = count;
  assign halted    = (state == SB_HALT);

endmodule

// File: tb/tb_fifo_scoreboard.sv
// Bench: three scoreboards (READ_LAT=0, READ_LAT=1, STOP_ON_ERR=1) share stimulus.
// A queue-based model predicts every output each cycle; a monitor compares.
module tb_fifo_scoreboard;

  localparam int DW = 4;
  localparam int D  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic          vld_in, vld_out, clr_err;
  logic [DW-1:0] data_in;
  logic [DW-1:0] dout [3];

  logic [CW-1:0] occ [3];
  logic          ov [3], ud [3], mm [3], hl [3];
  logic [15:0]   ecn [3];
  logic [DW-1:0] eex [3], eac [3];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      fifo_scoreboard #(
        .DATA_W      (DW),
        .DEPTH       (D),
        .READ_LAT    ((g == 1) ? 1 : 0),
        .STOP_ON_ERR ((g == 2) ? 1 : 0)
      ) u_dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .vld_in        (vld_in),
        .data_in       (data_in),
        .vld_out       (vld_out),
        .data_out      (dout[g]),
        .clr_err       (clr_err),
        .occupancy     (occ[g]),
        .err_overflow  (ov[g]),
        .err_underflow (ud[g]),
        .err_mismatch  (mm[g]),
        .err_cnt       (ecn[g]),
        .err_exp       (eex[g]),
        .err_act       (eac[g]),
        .halted        (hl[g])
      );
    end
  endgenerate

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mq [3][$];
  bit            m_ov [3], m_ud [3], m_mm [3], m_h [3], m_pv [3];
  logic [DW-1:0] m_pe [3], m_ex [3], m_ac [3];
  int            m_cnt [3];

  task automatic m_reset(input int c);
    mq[c].delete();
    m_ov[c] = 0; m_ud[c] = 0; m_mm[c] = 0; m_h[c] = 0; m_pv[c] = 0;
    m_pe[c] = '0; m_ex[c] = '0; m_ac[c] = '0; m_cnt[c] = 0;
  endtask

  task automatic m_step(input int c);
    int            sz = mq[c].size();
    bit            ovf, udf, mis, dpush, dpop, ne;
    logic [DW-1:0] e = '0;
    logic [DW-1:0] cexp = '0;
    logic [DW-1:0] d = dout[c];
    if (m_h[c]) begin
      m_pv[c] = 0;
      if (clr_err) m_reset(c);
      return;
    end
    ovf   = vld_in && !vld_out && sz == D;
    udf   = vld_out && !vld_in && sz == 0;
    dpush = vld_in && (sz < D || vld_out);
    dpop  = vld_out && (sz > 0 || vld_in);
    if (dpush) mq[c].push_back(data_in);
    if (dpop)  e = mq[c].pop_front();
    if (c == 1) begin
      mis  = m_pv[c] && (m_pe[c] != d);
      cexp = m_pe[c];
      m_pv[c] = dpop;
      m_pe[c] = e;
    end else begin
      mis  = dpop && (e != d);
      cexp = e;
    end
    ne = ovf || udf || mis;
    if (clr_err) begin
      m_ov[c] = ovf; m_ud[c] = udf; m_mm[c] = mis;
      m_cnt[c] = ne ? 1 : 0;
      m_ex[c] = mis ? cexp : '0;
      m_ac[c] = mis ? d : '0;
    end else begin
      if (mis && !m_mm[c]) begin
        m_ex[c] = cexp;
        m_ac[c] = d;
      end
      m_ov[c] |= ovf; m_ud[c] |= udf; m_mm[c] |= mis;
      if (ne && m_cnt[c] < 65535) m_cnt[c]++;
    end
    if (c == 2 && ne) m_h[c] = 1;
  endtask

  function automatic logic [DW-1:0] ideal(input int c, input logic [DW-1:0] din);
    if (c == 1) return m_pe[c];
    if (mq[c].size() == 0) return din;
    return mq[c][0];
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [CW-1:0] occ;
    logic          ov, ud, mm, h;
    logic [15:0]   cnt;
    logic [DW-1:0] ex, ac;
  } snap_t;
  typedef snap_t [2:0] snap3_t;

  snap3_t sbq [$];

  // Predict each cycle's outputs and queue them.
  always @(posedge clk) begin
    snap3_t s;
    for (int c = 0; c < 3; c++) begin
      if (!rst_b) m_reset(c);
      else        m_step(c);
      s[c].occ = CW'(mq[c].size());
      s[c].ov  = m_ov[c];
      s[c].ud  = m_ud[c];
      s[c].mm  = m_mm[c];
      s[c].h   = m_h[c];
      s[c].cnt = 16'(m_cnt[c]);
      s[c].ex  = m_ex[c];
      s[c].ac  = m_ac[c];
    end
    sbq.push_back(s);
  end

  // Monitor: pop one prediction per cycle and compare on the falling edge.
  always @(negedge clk) begin
    snap3_t s;
    if (sbq.size() > 0) begin
      s = sbq.pop_front();
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("u%0d occupancy", g), occ[g], s[g].occ);
        chk($sformatf("u%0d flags", g), {ov[g], ud[g], mm[g], hl[g]},
            {s[g].ov, s[g].ud, s[g].mm, s[g].h});
        chk($sformatf("u%0d err_cnt", g), ecn[g], s[g].cnt);
        chk($sformatf("u%0d err_exp", g), eex[g], s[g].ex);
        chk($sformatf("u%0d err_act", g), eac[g], s[g].ac);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit vi, input logic [DW-1:0] din, input bit vo, input bit clr,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    vld_in = vi; data_in = din; vld_out = vo; clr_err = clr;
    dout[0] = d0; dout[1] = d1; dout[2] = d2;
    @(negedge clk);
  endtask

  task automatic good(input bit vi, input logic [DW-1:0] din, input bit vo, input bit clr);
    drive(vi, din, vo, clr, ideal(0, din), ideal(1, din), ideal(2, din));
  endtask

  // Empty every model and clear all errors / halts.
  task automatic clean();
    for (int i = 0; i < D; i++) good(0, '0, 1, 0);
    good(0, '0, 0, 1);
    good(0, '0, 0, 0);
  endtask

  initial begin
    vld_in = 0; vld_out = 0; clr_err = 0; data_in = '0;
    dout[0] = '0; dout[1] = '0; dout[2] = '0;
    repeat (3) @(negedge clk);
    chk("reset occupancy", occ[0], 0);
    chk("reset flags", {ov[0], ud[0], mm[0], hl[2]}, 0);
    rst_b = 1'b1;
    good(0, '0, 0, 0);

    // Fill then drain with matching data.
    for (int i = 1; i <= 4; i++) good(1, 4'(i), 0, 0);
    chk("fill occupancy", occ[0], 4);
    for (int i = 0; i < 4; i++) good(0, '0, 1, 0);
    chk("drain occupancy", occ[0], 0);
    chk("drain flags", {ov[0], ud[0], mm[0]}, 0);
    good(0, '0, 0, 0);
    chk("drain lat1 mismatch", mm[1], 0);

    // Five writes, no reads.
    for (int i = 1; i <= 5; i++) good(1, 4'(i), 0, 0);
    chk("overflow flag", ov[0], 1);
    chk("overflow err_cnt", ecn[0], 1);
    chk("overflow occupancy", occ[0], 4);
    chk("overflow halts", hl[2], 1);
    clean();

    // Fall-through on empty.
    good(1, 4'hA, 1, 0);
    chk("fallthru occupancy", occ[0], 0);
    chk("fallthru flags", {ov[0], ud[0], mm[0]}, 0);
    good(0, '0, 0, 0);
    chk("fallthru lat1", {mm[1], ecn[1]}, 0);

    // Delayed-read mismatch.
    good(1, 4'h3, 0, 0);
    good(0, '0, 1, 0);
    drive(0, '0, 0, 0, ideal(0, '0), 4'h5, ideal(2, '0));
    chk("lat1 mismatch", mm[1], 1);
    chk("lat1 err_exp", eex[1], 4'h3);
    chk("lat1 err_act", eac[1], 4'h5);
    chk("lat0 no mismatch", mm[0], 0);
    clean();

    // Halt on underflow, then recover.
    good(0, '0, 1, 0);
    chk("halt on underflow", {hl[2], ud[2]}, 2'b11);
    chk("halt err_cnt", ecn[2], 1);
    good(1, 4'h7, 0, 0);
    drive(0, '0, 1, 0, ideal(0, '0), ideal(1, '0), 4'hF);
    good(0, '0, 0, 0);
    chk("halt frozen err_cnt", ecn[2], 1);
    chk("halt frozen occupancy", occ[2], 0);
    good(0, '0, 0, 1);
    chk("clr leaves halt", hl[2], 0);
    chk("clr flush", {occ[2], ov[2], ud[2], mm[2], ecn[2]}, 0);

    // New error wins over clear.
    good(0, '0, 1, 1);
    chk("err beats clr flag", ud[0], 1);
    chk("err beats clr cnt", ecn[0], 1);
    clean();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      bit            vi, vo, clr;
      logic [DW-1:0] din;
      logic [DW-1:0] d [3];
      vi  = ($urandom_range(0, 2) != 0);
      vo  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 19) == 0);
      din = 4'($urandom_range(0, 15));
      for (int c = 0; c < 3; c++)
        d[c] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : ideal(c, din);
      drive(vi, din, vo, clr, d[0], d[1], d[2]);
    end
    clean();

    // Reset with three entries and a delayed compare in flight.
    for (int i = 0; i < 4; i++) good(1, 4'(i + 8), 0, 0);
    good(0, '0, 1, 0);
    chk("pre-reset occupancy", occ[0], 3);
    #2 rst_b = 1'b0;
    #1;
    for (int g = 0; g < 3; g++)
      chk($sformatf("u%0d async reset", g),
          {occ[g], ov[g], ud[g], mm[g], hl[g], ecn[g], eex[g], eac[g]}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    drive(0, '0, 1, 0, 4'hF, 4'hF, 4'hF);
    chk("post-reset underflow", {ud[0], mm[0], ud[1], mm[1]}, 4'b1010);
    chk("post-reset err_cnt", ecn[1], 1);
    drive(0, '0, 0, 0, 4'hF, 4'hF, 4'hF);
    chk("post-reset no pending", mm[1], 0);
    good(0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_scoreboard.md
FIFO_SCOREBOARD -- requirements
Module: fifo_scoreboard

Interface
REQ-001 SHALL take parameter DATA_W, default 4: data width of the monitored FIFO.
REQ-002 SHALL take parameter DEPTH, default 4: capacity of the monitored FIFO, power of two, at least 2.
REQ-003 SHALL take parameter READ_LAT, default 0: 0 means read data is valid in the same cycle as vld_out; 1 means it is valid in the next cycle.
REQ-004 SHALL take parameter STOP_ON_ERR, default 0: 1 means the block halts at the first error.
REQ-005 SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-006 SHALL have port rst_b, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port vld_in, input, 1 bit: write attempt.
REQ-008 SHALL have port data_in, input, DATA_W bits: write data.
REQ-009 SHALL have port vld_out, input, 1 bit: read attempt.
REQ-010 SHALL have port data_out, input, DATA_W bits: read data from the FIFO under test.
REQ-011 SHALL have port clr_err, input, 1 bit: clears errors and leaves HALT.
REQ-012 SHALL have port occupancy, output, CW=$clog2(DEPTH)+1 bits: entry count of the model.
REQ-013 SHALL have port err_overflow, err_underflow and err_mismatch, output, 1 bit each: sticky error flags.
REQ-014 SHALL have port err_cnt, output, 16 bits: saturating count of error cycles.
REQ-015 SHALL have port err_exp and err_act, output, DATA_W bits each: expected and actual data of the first mismatch.
REQ-016 SHALL have port halted, output, 1 bit: high when the FSM is in HALT.

Function
REQ-017 SHALL hold a reference model: DEPTH x DATA_W storage, wr_ptr and rd_ptr that wrap modulo DEPTH, and a CW-bit count.
REQ-018 SHALL define push as vld_in && (count<DEPTH || vld_out); on push, store data_in at wr_ptr and advance wr_ptr.
REQ-019 SHALL define pop as vld_out && (count>0 || vld_in); on pop, advance rd_ptr.
REQ-020 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged when both or neither occur.
REQ-021 SHALL set err_overflow when vld_in && !vld_out && count==DEPTH, and SHALL drop that write.
REQ-022 SHALL set err_underflow when vld_out && !vld_in && count==0, and SHALL not move any pointer.
REQ-023 SHALL take expected data on pop as data_in when count==0 (fall-through), and mem[rd_ptr] otherwise.
REQ-024 SHALL compare expected data to data_out in the pop cycle when READ_LAT=0; when READ_LAT=1 it SHALL register the expected data and the pop, and compare one cycle later.
REQ-025 SHALL set err_mismatch on an unequal compare, and SHALL capture err_exp and err_act only while err_mismatch is clear.
REQ-026 SHALL increment err_cnt by 1 in each cycle with one or more new errors, saturating at 16'hFFFF.
REQ-027 SHALL run an FSM with states RUN and HALT, where RUN checks and updates the model.
REQ-028 SHALL go from RUN to HALT on any error when STOP_ON_ERR=1; STOP_ON_ERR=0 stays in RUN.
REQ-029 SHALL freeze the model, flags and counter while in HALT, and ignore all inputs except clr_err.
REQ-030 SHALL on clr_err clear the flags, err_cnt, err_exp and err_act.
REQ-031 SHALL on clr_err while in HALT also flush the model (pointers and count to 0) and return to RUN.
REQ-032 SHALL let a new error win over clr_err in the same cycle while in RUN: that flag is set and err_cnt becomes 1.
REQ-033 SHALL drive occupancy directly from count, with no added latency.

Reset
REQ-034 SHALL on rst_b low set pointers, count, occupancy, flags, err_cnt, err_exp, err_act, the pipeline registers and halted to 0, and the FSM to RUN.
REQ-035 SHALL on reset asserted mid-operation discard all model contents, with no compare pending after release.
REQ-036 SHALL leave model storage contents unspecified after reset; they are never read while count==0.

Structure
REQ-037 SHALL put in shared package fifo_sb_pkg: the FSM state enum (SB_RUN, SB_HALT) and the 16-bit error-counter width constant.
REQ-038 SHALL put the storage, pointers and count in sub-module fifo_sb_model, with a push/pop/flush interface and an expected-data output.
REQ-039 SHALL place error detection, the READ_LAT pipeline, the FSM and the counters in the top module.

Verification
REQ-040 SHALL cover, DEPTH=4, READ_LAT=0: push 1,2,3,4 then pop 4 times with matching data -> no flags, occupancy 4 then 0.
REQ-041 SHALL cover, DEPTH=4: push 5 times with no reads -> err_overflow=1 after the 5th cycle, err_cnt=1, occupancy stays 4.
REQ-042 SHALL cover, when empty: vld_in=vld_out=1 with data_in=0xA and data_out=0xA -> no error, occupancy stays 0.
REQ-043 SHALL cover, READ_LAT=1: push 0x3, pop with data_out=0x5 one cycle later -> err_mismatch=1, err_exp=0x3, err_act=0x5.
REQ-044 SHALL cover, STOP_ON_ERR=1: underflow on empty -> halted=1, further mismatches leave err_cnt=1; then clr_err -> halted=0, occupancy 0, flags 0.
REQ-045 SHALL cover reset asserted with occupancy 3 -> all outputs 0 asynchronously, with no error on the first pop attempt after release (underflow only).
